// File: rtl/softmax_max_sub.sv
// Softmax pre-stage: buffers a 1-row or 8-row frame of signed logits, tracks the frame max,
// then emits each row as unsigned per-lane offsets (max - x).
module softmax_max_sub #(
  parameter int unsigned bw  = 8,
  parameter int unsigned col = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [col*bw-1:0] in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [col*bw-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        out_row,
  output logic              out_last
);

  typedef enum logic [1:0] {StIdle, StLoad, StEmit} state_e;

  state_e            state_q, state_d;
  logic [col*bw-1:0] buf_q [col];
  logic [bw-1:0]     max_q, max_d;
  logic [2:0]        wr_q, wr_d, rd_q, rd_d, rd_nxt, buf_waddr;
  logic              mode_q, mode_d, buf_we;
  logic [bw-1:0]     in_max;
  logic [col*bw-1:0] out_q, out_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [2:0]        out_row_q, out_row_d;

  function automatic logic [bw-1:0] row_max(input logic [col*bw-1:0] row);
    logic [bw-1:0] m;
    m = row[bw-1:0];
    for (int i = 1; i < col; i++) begin
      if ($signed(row[i*bw +: bw]) > $signed(m)) m = row[i*bw +: bw];
    end
    return m;
  endfunction

  // max >= x always, so the low bw bits of the bw+1-bit difference equal the plain bw-bit result.
  function automatic logic [col*bw-1:0] offsets(input logic [bw-1:0] m,
                                                input logic [col*bw-1:0] row);
    logic [col*bw-1:0] r;
    for (int i = 0; i < col; i++) r[i*bw +: bw] = m - row[i*bw +: bw];
    return r;
  endfunction

  function automatic logic [2:0] last_row(input logic m);
    return m ? 3'(col - 1) : 3'd0;
  endfunction

  assign in_max = row_max(in);
  assign rd_nxt = rd_q + 3'd1;

  always_comb begin
    state_d     = state_q;
    wr_d        = wr_q;
    rd_d        = rd_q;
    max_d       = max_q;
    mode_d      = mode_q;
    buf_we      = 1'b0;
    buf_waddr   = wr_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    out_row_d   = out_row_q;
    out_last_d  = out_last_q;
    in_ready    = (state_q != StEmit);
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          buf_we    = 1'b1;
          buf_waddr = 3'd0;
          max_d     = in_max;
          mode_d    = mode;
          wr_d      = 3'd1;
          if (!mode) begin
            state_d     = StEmit;
            rd_d        = 3'd0;
            out_valid_d = 1'b1;
            out_d       = offsets(in_max, in);
            out_row_d   = 3'd0;
            out_last_d  = 1'b1;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (in_valid) begin
          buf_we = 1'b1;
          max_d  = ($signed(in_max) > $signed(max_q)) ? in_max : max_q;
          wr_d   = wr_q + 3'd1;
          if (wr_q == 3'(col - 1)) begin
            // Row 0 is already buffered; prime the output register with it.
            state_d     = StEmit;
            rd_d        = 3'd0;
            out_valid_d = 1'b1;
            out_d       = offsets(max_d, buf_q[0]);
            out_row_d   = 3'd0;
            out_last_d  = (last_row(mode_q) == 3'd0);
          end
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = StIdle;
            wr_d        = 3'd0;
            rd_d        = 3'd0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            out_row_d   = 3'd0;
          end else begin
            rd_d       = rd_nxt;
            out_d      = offsets(max_q, buf_q[rd_nxt]);
            out_row_d  = rd_nxt;
            out_last_d = (rd_nxt == last_row(mode_q));
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      max_q       <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      mode_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_row_q   <= '0;
      out_last_q  <= 1'b0;
      for (int i = 0; i < col; i++) buf_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      max_q       <= max_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      mode_q      <= mode_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_row_q   <= out_row_d;
      out_last_q  <= out_last_d;
      if (buf_we) buf_q[buf_waddr] <= in;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_row   = out_row_q;
  assign out_last  = out_last_q;

endmodule
